command_initiator: RTL

//  Host-side master for the 6-byte RoC UART command protocol: frames one request as
//  {CMD, P[31:24], P[23:16], P[15:8], P[7:0], 8'hA5}, sends it over uart_tx and checks

---
 rtl/command_initiator_if.sv | 24 ++
 rtl/command_initiator.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_initiator_if.sv
// Request/response handshake between a host controller and the command_initiator.
// The initiator itself sits on the slave modport; the requesting logic uses master.
interface command_initiator_if;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [7:0]  i_req_cmd;
   logic [31:0] i_req_payload;
   logic [7:0]  i_resp_len;
   logic        o_resp_valid;
   logic [7:0]  o_resp_data;
   logic        o_done;
   logic [1:0]  o_error;
   logic        o_busy;

   modport master (
      output i_req_valid, i_req_cmd, i_req_payload, i_resp_len,
      input  o_req_ready, o_resp_valid, o_resp_data, o_done, o_error, o_busy
   );

   modport slave (
      input  i_req_valid, i_req_cmd, i_req_payload, i_resp_len,
      output o_req_ready, o_resp_valid, o_resp_data, o_done, o_error, o_busy
   );
endinterface

// File: rtl/command_initiator.sv
// Host-side master of the 6-byte RoC UART command protocol: sends a framed request,
// verifies every byte's echo, then collects the requested number of response bytes.
module command_initiator #(
   parameter int unsigned BAUD_DIVIDER_COUNT = 20,
   parameter int unsigned TIMEOUT_CYCLES     = 65535,
   parameter logic [7:0]  EOC                = 8'hA5
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_rx,
   output logic o_tx,
   command_initiator_if.slave req_if
);

   localparam int unsigned BW   = $clog2(BAUD_DIVIDER_COUNT + 1);
   localparam int unsigned HALF = BAUD_DIVIDER_COUNT / 2;
   localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_ECHO    = 2'd1;
   localparam logic [1:0] ERR_ECHO_TO = 2'd2;
   localparam logic [1:0] ERR_RESP_TO = 2'd3;

   typedef enum logic [2:0] {IDLE, SEND, ECHO, RESP, DONE} state_t;

   state_t          state_q, state_d;
   logic [5:0][7:0] frame_q, frame_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [7:0]      len_q, len_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            ready_q, ready_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [1:0]      error_q, error_d;
   logic            resp_valid_q, resp_valid_d;
   logic [7:0]      resp_data_q, resp_data_d;

   logic            tx_q, tx_d;
   logic            tx_busy_q, tx_busy_d;
   logic [8:0]      tx_sh_q, tx_sh_d;
   logic [3:0]      tx_bit_q, tx_bit_d;
   logic [BW-1:0]   tx_baud_q, tx_baud_d;

   logic            rx_s1_q, rx_s2_q;
   logic            rx_busy_q, rx_busy_d;
   logic [3:0]      rx_bit_q, rx_bit_d;
   logic [BW-1:0]   rx_baud_q, rx_baud_d;
   logic [7:0]      rx_sh_q, rx_sh_d;
   logic            rx_new_q, rx_new_d;
   logic [7:0]      rx_data_q, rx_data_d;

   logic            tx_start_c;
   logic [7:0]      tx_byte_c;
   logic            timeout_c;
   logic [TW-1:0]   timer_inc_c;

   assign timeout_c   = (timer_q == TW'(TIMEOUT_CYCLES - 1));
   assign timer_inc_c = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + TW'(1);

   // Protocol sequencer
   always_comb begin
      state_d      = state_q;
      frame_d      = frame_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      timer_d      = timer_q;
      ready_d      = ready_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      error_d      = error_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      tx_start_c   = 1'b0;
      tx_byte_c    = frame_q[idx_q];
      case (state_q)
         IDLE: begin
            if (req_if.i_req_valid && ready_q) begin
               frame_d = {EOC, req_if.i_req_payload[7:0], req_if.i_req_payload[15:8],
                          req_if.i_req_payload[23:16], req_if.i_req_payload[31:24],
                          req_if.i_req_cmd};
               len_d   = req_if.i_resp_len;
               idx_d   = 3'd0;
               cnt_d   = 8'd0;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               error_d = ERR_OK;
               state_d = SEND;
            end
         end
         SEND: begin
            tx_start_c = 1'b1;
            timer_d    = '0;
            state_d    = ECHO;
         end
         ECHO: begin
            // A byte arriving on the threshold cycle still counts as received
            if (rx_new_q) begin
               timer_d = '0;
               if (rx_data_q != frame_q[idx_q]) begin
                  error_d = ERR_ECHO;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else if (idx_q != 3'd5) begin
                  idx_d   = idx_q + 3'd1;
                  state_d = SEND;
               end else if (len_q == 8'd0) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = RESP;
               end
            end else if (timeout_c) begin
               error_d = ERR_ECHO_TO;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               timer_d = timer_inc_c;
            end
         end
         RESP: begin
            if (rx_new_q) begin
               timer_d      = '0;
               resp_valid_d = 1'b1;
               resp_data_d  = rx_data_q;
               cnt_d        = cnt_q + 8'd1;
               if (cnt_q + 8'd1 == len_q) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end else if (timeout_c) begin
               error_d = ERR_RESP_TO;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               timer_d = timer_inc_c;
            end
         end
         DONE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // 8N1 serializer; start bit is driven on the load edge
   always_comb begin
      tx_d      = tx_q;
      tx_busy_d = tx_busy_q;
      tx_sh_d   = tx_sh_q;
      tx_bit_d  = tx_bit_q;
      tx_baud_d = tx_baud_q;
      if (tx_start_c) begin
         tx_d      = 1'b0;
         tx_sh_d   = {1'b1, tx_byte_c};
         tx_bit_d  = 4'd0;
         tx_baud_d = '0;
         tx_busy_d = 1'b1;
      end else if (tx_busy_q) begin
         if (tx_baud_q == BW'(BAUD_DIVIDER_COUNT - 1)) begin
            tx_baud_d = '0;
            if (tx_bit_q == 4'd9) begin
               tx_busy_d = 1'b0;
            end else begin
               tx_d     = tx_sh_q[0];
               tx_sh_d  = {1'b0, tx_sh_q[8:1]};
               tx_bit_d = tx_bit_q + 4'd1;
            end
         end else begin
            tx_baud_d = tx_baud_q + BW'(1);
         end
      end
   end

   // 8N1 deserializer sampling mid-bit on the synchronized line
   always_comb begin
      rx_busy_d = rx_busy_q;
      rx_bit_d  = rx_bit_q;
      rx_baud_d = rx_baud_q;
      rx_sh_d   = rx_sh_q;
      rx_new_d  = 1'b0;
      rx_data_d = rx_data_q;
      if (!rx_busy_q) begin
         if (!rx_s2_q) begin
            rx_busy_d = 1'b1;
            rx_bit_d  = 4'd0;
            rx_baud_d = '0;
         end
      end else if (rx_bit_q == 4'd0) begin
         if (rx_baud_q == BW'(HALF - 1)) begin
            rx_baud_d = '0;
            if (rx_s2_q) rx_busy_d = 1'b0;
            else         rx_bit_d  = 4'd1;
         end else begin
            rx_baud_d = rx_baud_q + BW'(1);
         end
      end else if (rx_baud_q == BW'(BAUD_DIVIDER_COUNT - 1)) begin
         rx_baud_d = '0;
         if (rx_bit_q == 4'd9) begin
            rx_busy_d = 1'b0;
            if (rx_s2_q) begin
               rx_new_d  = 1'b1;
               rx_data_d = rx_sh_q;
            end
         end else begin
            rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 4'd1;
         end
      end else begin
         rx_baud_d = rx_baud_q + BW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         frame_q      <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         len_q        <= '0;
         timer_q      <= '0;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= ERR_OK;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         tx_q         <= 1'b1;
         tx_busy_q    <= 1'b0;
         tx_sh_q      <= '0;
         tx_bit_q     <= '0;
         tx_baud_q    <= '0;
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_busy_q    <= 1'b0;
         rx_bit_q     <= '0;
         rx_baud_q    <= '0;
         rx_sh_q      <= '0;
         rx_new_q     <= 1'b0;
         rx_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         frame_q      <= frame_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         timer_q      <= timer_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         tx_q         <= tx_d;
         tx_busy_q    <= tx_busy_d;
         tx_sh_q      <= tx_sh_d;
         tx_bit_q     <= tx_bit_d;
         tx_baud_q    <= tx_baud_d;
         rx_s1_q      <= i_rx;
         rx_s2_q      <= rx_s1_q;
         rx_busy_q    <= rx_busy_d;
         rx_bit_q     <= rx_bit_d;
         rx_baud_q    <= rx_baud_d;
         rx_sh_q      <= rx_sh_d;
         rx_new_q     <= rx_new_d;
         rx_data_q    <= rx_data_d;
      end
   end

   assign o_tx                = tx_q;
   assign req_if.o_req_ready  = ready_q;
   assign req_if.o_resp_valid = resp_valid_q;
   assign req_if.o_resp_data  = resp_data_q;
   assign req_if.o_done       = done_q;
   assign req_if.o_error      = error_q;
   assign req_if.o_busy       = busy_q;

endmodule
